// File: rtl/cute_lock_pkg.sv
// Shared types and width helpers for the Cute-Lock key scheduler.
`timescale 1ns/1ps
package cute_lock_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ARMED = 2'd2,
    RUN   = 2'd3
  } sched_state_t;

  function automatic int phase_w(input int period);
    return (period > 1) ? $clog2(period) : 1;
  endfunction

  // One code point past the last slot is always representable so bad indices can be flagged.
  function automatic int idx_w(input int num_keys);
    return (num_keys > 0) ? $clog2(num_keys + 1) : 1;
  endfunction

endpackage

// File: rtl/cute_phase_counter.sv
// Wrap counter that mirrors the locked FSM's internal counter; updates on the falling edge.
`timescale 1ns/1ps
module cute_phase_counter #(
  parameter int PERIOD = 4,
  parameter int PW     = 2
) (
  input  logic          clk,
  input  logic          rst,
  output logic [PW-1:0] phase,
  output logic          last
);

  logic [PW-1:0] phase_q;
  logic [PW-1:0] phase_d;

  always_comb begin
    last    = (phase_q == PW'(PERIOD - 1));
    phase_d = last ? '0 : phase_q + PW'(1);
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/cute_key_scheduler.sv
// Time-varying unlock key source for a Cute-Lock locked FSM.
// Optional CUTE_KEY_SCHED_ZEROIZE_EN adds a zeroize input that wipes all key slots.
`timescale 1ns/1ps
module cute_key_scheduler
  import cute_lock_pkg::*;
#(
  parameter int               KEY_W     = 5,
  parameter int               NUM_KEYS  = 2,
  parameter int               PHASE_LEN = 2,
  parameter logic [KEY_W-1:0] DECOY_KEY = '0
) (
  input  logic                                         clk,
  input  logic                                         rst,
`ifdef CUTE_KEY_SCHED_ZEROIZE_EN
  input  logic                                         zeroize,
`endif
  input  logic                                         cfg_valid,
  output logic                                         cfg_ready,
  input  logic [idx_w(NUM_KEYS)-1:0]                   cfg_idx,
  input  logic [KEY_W-1:0]                             cfg_key,
  output logic                                         cfg_err,
  input  logic                                         arm,
  output logic [KEY_W-1:0]                             keyinput,
  output logic                                         running,
  output logic [phase_w(NUM_KEYS*PHASE_LEN)-1:0]       phase
);

  localparam int PERIOD = NUM_KEYS * PHASE_LEN;
  localparam int PW     = phase_w(PERIOD);

  sched_state_t                     state_q, state_d;
  logic [NUM_KEYS-1:0][KEY_W-1:0]   slots_q, slots_d;
  logic [NUM_KEYS-1:0]              mask_q, mask_d;
  logic                             cfg_err_q, cfg_err_d;
  logic                             cfg_ready_q, cfg_ready_d;
  logic                             running_q, running_d;
  logic                             last_phase;
  logic                             wr_acc;
  logic                             idx_ok;

  cute_phase_counter #(
    .PERIOD (PERIOD),
    .PW     (PW)
  ) u_phase (
    .clk   (clk),
    .rst   (rst),
    .phase (phase),
    .last  (last_phase)
  );

  // Writes land before the arm check so a simultaneous write+arm sees the updated mask.
  always_comb begin
    state_d   = state_q;
    slots_d   = slots_q;
    mask_d    = mask_q;
    cfg_err_d = 1'b0;
    wr_acc    = cfg_valid && cfg_ready_q;
    idx_ok    = int'(cfg_idx) < NUM_KEYS;

    for (int i = 0; i < NUM_KEYS; i++) begin
      if (wr_acc && idx_ok && (int'(cfg_idx) == i)) begin
        slots_d[i] = cfg_key;
        mask_d[i]  = 1'b1;
      end
    end
    cfg_err_d = wr_acc && !idx_ok;

    case (state_q)
      IDLE: begin
        if (arm && (&mask_d)) begin
          state_d = ARMED;
        end else if (wr_acc && idx_ok) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (arm && (&mask_d)) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (!arm) begin
          state_d = LOAD;
        end else if (last_phase) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!arm) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef CUTE_KEY_SCHED_ZEROIZE_EN
    if (zeroize) begin
      slots_d   = '0;
      mask_d    = '0;
      state_d   = IDLE;
      cfg_err_d = 1'b0;
    end
`endif

    cfg_ready_d = (state_d == IDLE) || (state_d == LOAD);
    running_d   = (state_d == RUN);
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      slots_q     <= '0;
      mask_q      <= '0;
      cfg_err_q   <= 1'b0;
      cfg_ready_q <= 1'b1;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      slots_q     <= slots_d;
      mask_q      <= mask_d;
      cfg_err_q   <= cfg_err_d;
      cfg_ready_q <= cfg_ready_d;
      running_q   <= running_d;
    end
  end

  // Selected from current state and phase so the lock sees the right key at the same edge.
  always_comb begin
    keyinput = DECOY_KEY;
    if (state_q == RUN) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if ((int'(phase) / PHASE_LEN) == i) begin
          keyinput = slots_q[i];
        end
      end
    end
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;
  assign running   = running_q;

endmodule

// File: tb/tb_cute_key_scheduler.sv
// Directed self-checking bench for cute_key_scheduler (KEY_W=5, NUM_KEYS=2, PHASE_LEN=2).
`timescale 1ns/1ps
module tb_cute_key_scheduler;

  logic       clk;
  logic       rst;
  logic       zeroize;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_idx;
  logic [4:0] cfg_key;
  logic       cfg_err;
  logic       arm;
  logic [4:0] keyinput;
  logic       running;
  logic [1:0] phase;

  int n_checks;
  int n_fail;
  int exp_phase;

  cute_key_scheduler #(
    .KEY_W     (5),
    .NUM_KEYS  (2),
    .PHASE_LEN (2),
    .DECOY_KEY (5'd0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef CUTE_KEY_SCHED_ZEROIZE_EN
    .zeroize   (zeroize),
`endif
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_idx   (cfg_idx),
    .cfg_key   (cfg_key),
    .cfg_err   (cfg_err),
    .arm       (arm),
    .keyinput  (keyinput),
    .running   (running),
    .phase     (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active (falling) edge and sample 1ns later; the phase model follows the lock counter.
  task automatic tick();
    @(negedge clk);
    #1;
    exp_phase = (exp_phase + 1) % 4;
  endtask

  task automatic do_reset();
    cfg_valid = 1'b0;
    cfg_idx   = 2'd0;
    cfg_key   = 5'd0;
    arm       = 1'b0;
    zeroize   = 1'b0;
    rst       = 1'b1;
    exp_phase = 0;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_running(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (running === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("[TB] FAIL %s_timeout: running=%0b never reached required 1", name, running);
    end
    n_checks++;
    if (phase !== 2'(exp_phase) || exp_phase != 0) begin
      n_fail++;
      $display("[TB] FAIL %s_start_phase: got %0d (model %0d) required 0", name, phase, exp_phase);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (phase !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_phase: got %0d required 0", phase); end
    n_checks++;
    if (keyinput !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_key: got %0d required 0", keyinput); end
    n_checks++;
    if (running !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_running: got %0b required 0", running); end
    n_checks++;
    if (cfg_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_ready: got %0b required 1", cfg_ready); end
    n_checks++;
    if (cfg_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %0b required 0", cfg_err); end
  endtask

  task automatic test_idle_arm();
    arm = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (phase !== 2'(exp_phase)) begin
        n_fail++; $display("[TB] FAIL idle_phase: cycle %0d got %0d required %0d", i, phase, exp_phase);
      end
      n_checks++;
      if (keyinput !== 5'd0 || running !== 1'b0) begin
        n_fail++; $display("[TB] FAIL idle_arm: cycle %0d key=%0d running=%0b required 0/0", i, keyinput, running);
      end
    end
    arm = 1'b0;
    tick();
  endtask

  task automatic test_load_and_run();
    logic [4:0] exp_key;
    bit         decoy;
    cfg_valid = 1'b1; cfg_idx = 2'd0; cfg_key = 5'd28;
    tick();
    cfg_idx = 2'd1; cfg_key = 5'd2;
    tick();
    cfg_valid = 1'b0;
    arm = 1'b1;
    tick();
    n_checks++;
    if (cfg_ready !== 1'b0 || running !== 1'b0) begin
      n_fail++; $display("[TB] FAIL armed_state: ready=%0b running=%0b required 0/0", cfg_ready, running);
    end
    wait_running("run");
    decoy = 1'b0;
    for (int i = 0; i < 12; i++) begin
      exp_key = (exp_phase < 2) ? 5'd28 : 5'd2;
      n_checks++;
      if (keyinput !== exp_key || running !== 1'b1) begin
        n_fail++; decoy = 1'b1;
        $display("[TB] FAIL run_key: phase %0d got %0d running=%0b required %0d", exp_phase, keyinput, running, exp_key);
      end
      tick();
    end
    n_checks++;
    if (decoy !== 1'b0) begin n_fail++; $display("[TB] FAIL lock_model: decoy entered=%0b required 0", decoy); end
  endtask

  task automatic test_drop_arm();
    for (int i = 0; i < 6 && exp_phase != 1; i++) tick();
    arm = 1'b0;
    tick();
    n_checks++;
    if (running !== 1'b0 || keyinput !== 5'd0 || cfg_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL drop_arm: running=%0b key=%0d ready=%0b required 0/0/1", running, keyinput, cfg_ready);
    end
    arm = 1'b1;
    tick();
    n_checks++;
    if (cfg_ready !== 1'b0 || running !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rearm_armed: ready=%0b running=%0b required 0/0", cfg_ready, running);
    end
    wait_running("rearm");
    n_checks++;
    if (keyinput !== 5'd28) begin n_fail++; $display("[TB] FAIL rearm_key0: got %0d required 28", keyinput); end
    tick(); tick();
    n_checks++;
    if (keyinput !== 5'd2) begin n_fail++; $display("[TB] FAIL rearm_key1: got %0d required 2", keyinput); end
  endtask

  task automatic test_bad_index();
    logic [4:0] exp_key;
    do_reset();
    cfg_valid = 1'b1; cfg_idx = 2'd0; cfg_key = 5'd5;
    tick();
    cfg_idx = 2'd3; cfg_key = 5'd7;
    tick();
    n_checks++;
    if (cfg_err !== 1'b1) begin n_fail++; $display("[TB] FAIL bad_idx_err: got %0b required 1", cfg_err); end
    cfg_valid = 1'b0;
    tick();
    n_checks++;
    if (cfg_err !== 1'b0) begin n_fail++; $display("[TB] FAIL bad_idx_pulse: got %0b required 0", cfg_err); end
    arm = 1'b1;
    repeat (6) tick();
    n_checks++;
    if (cfg_ready !== 1'b1 || running !== 1'b0) begin
      n_fail++; $display("[TB] FAIL partial_arm: ready=%0b running=%0b required 1/0", cfg_ready, running);
    end
    cfg_valid = 1'b1; cfg_idx = 2'd1; cfg_key = 5'd9;
    tick();
    cfg_valid = 1'b0;
    n_checks++;
    if (cfg_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL write_arm: ready=%0b required 0", cfg_ready); end
    wait_running("bad_idx");
    for (int i = 0; i < 4; i++) begin
      exp_key = (exp_phase < 2) ? 5'd5 : 5'd9;
      n_checks++;
      if (keyinput !== exp_key) begin
        n_fail++; $display("[TB] FAIL slot_kept: phase %0d got %0d required %0d", exp_phase, keyinput, exp_key);
      end
      tick();
    end
  endtask

  task automatic test_reset_in_run();
    for (int i = 0; i < 6 && exp_phase != 2; i++) tick();
    rst = 1'b1;
    #1;
    exp_phase = 0;
    n_checks++;
    if (phase !== 2'd0 || keyinput !== 5'd0 || running !== 1'b0 || cfg_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL async_rst: phase=%0d key=%0d running=%0b ready=%0b required 0/0/0/1",
                         phase, keyinput, running, cfg_ready);
    end
    @(negedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if (running !== 1'b0 || keyinput !== 5'd0 || cfg_ready !== 1'b1) begin
        n_fail++; $display("[TB] FAIL post_rst_arm: cycle %0d running=%0b key=%0d ready=%0b required 0/0/1",
                           i, running, keyinput, cfg_ready);
      end
    end
    arm = 1'b0;
  endtask

`ifdef CUTE_KEY_SCHED_ZEROIZE_EN
  task automatic test_zeroize();
    do_reset();
    cfg_valid = 1'b1; cfg_idx = 2'd0; cfg_key = 5'd28;
    tick();
    cfg_idx = 2'd1; cfg_key = 5'd2;
    tick();
    cfg_valid = 1'b0;
    arm = 1'b1;
    tick();
    wait_running("zeroize");
    zeroize = 1'b1; cfg_valid = 1'b1; cfg_idx = 2'd0; cfg_key = 5'd31;
    tick();
    zeroize = 1'b0; cfg_valid = 1'b0;
    n_checks++;
    if (running !== 1'b0 || keyinput !== 5'd0 || cfg_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL zeroize_run: running=%0b key=%0d ready=%0b required 0/0/1", running, keyinput, cfg_ready);
    end
    repeat (6) tick();
    n_checks++;
    if (running !== 1'b0 || cfg_ready !== 1'b1) begin
      n_fail++; $display("[TB] FAIL zeroize_mask: running=%0b ready=%0b required 0/1", running, cfg_ready);
    end
    arm = 1'b0;
    cfg_valid = 1'b1; cfg_idx = 2'd0; cfg_key = 5'd4;
    tick();
    zeroize = 1'b1; cfg_idx = 2'd1; cfg_key = 5'd6;
    tick();
    zeroize = 1'b0; cfg_idx = 2'd0; cfg_key = 5'd4;
    tick();
    cfg_valid = 1'b0; arm = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (cfg_ready !== 1'b1 || running !== 1'b0) begin
      n_fail++; $display("[TB] FAIL zeroize_drop_write: ready=%0b running=%0b required 1/0", cfg_ready, running);
    end
    arm = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_phase = 0;
    test_reset();
    test_idle_arm();
    test_load_and_run();
    test_drop_arm();
    test_bad_index();
    test_reset_in_run();
`ifdef CUTE_KEY_SCHED_ZEROIZE_EN
    test_zeroize();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
